// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial WIDTH-bit adder/subtractor built around a single
// adder_xor full-adder cell, processing operands LSB first over WIDTH cycles.
//
// Ports:
//   clk_in        clock, all state updates on the rising edge
//   rst_in        synchronous active-high reset (priority over start_in)
//   start_in      operation request, sampled only while idle
//   a_in, b_in    operands, captured on an accepted start
//   sub_in        0 = A+B, 1 = A-B (two's complement), captured on start
//   busy_out      high while an operation is shifting or signalling done
//   done_out      one-cycle pulse; result outputs valid from this cycle
//   result_out    sum/difference modulo 2^WIDTH, held until the next done
//   carry_out     carry out of the MSB (subtract: 1 = no borrow)
//   overflow_out  signed overflow (carry into MSB XOR carry out of MSB)

module adder_xor (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  input  logic control_in,
  output logic sum_out,
  output logic carry_out
);
  logic bx;

  // control_in inverts B so that, with c_in=1 on bit 0, the cell subtracts.
  assign bx        = b_in ^ control_in;
  assign sum_out   = a_in ^ bx ^ c_in;
  assign carry_out = (a_in & bx) | (a_in & c_in) | (bx & c_in);
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             overflow_out
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             cell_sum;
  logic             cell_carry;

  adder_xor u_cell (
    .a_in       (a_sh_q[0]),
    .b_in       (b_sh_q[0]),
    .c_in       (carry_q),
    .control_in (sub_q),
    .sum_out    (cell_sum),
    .carry_out  (cell_carry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          sub_d   = sub_in;
          // Seeding the carry with sub_in supplies the +1 of ~B+1.
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_sh_d = {cell_sum, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = cell_carry;
        if (cnt_q == LAST_BIT) begin
          // On the MSB, carry_q still holds the carry into the MSB.
          result_d = {cell_sum, res_sh_q[WIDTH-1:1]};
          cout_d   = cell_carry;
          ovf_d    = cell_carry ^ carry_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status flags are decoded straight from the state register.
  assign busy_out     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done_out     = (state_q == S_DONE);
  assign result_out   = result_q;
  assign carry_out    = cout_q;
  assign overflow_out = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub -- self-checking bench for serial_addsub (WIDTH=8).
// A cycle-level reference model predicts every output from plain arithmetic;
// directed scenarios add hand-computed literal expectations.

module tb_serial_addsub;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         start_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         sub_in = 1'b0;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] result_out;
  logic         carry_out;
  logic         overflow_out;

  int checks = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .sub_in       (sub_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_left counts remaining busy cycles: W+1 after an accepted start.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;
  logic         m_v = 1'b0;
  logic [W-1:0] p_res;
  logic         p_c;
  logic         p_v;
  logic         model_on = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start_in) begin
          logic [W:0]   full;
          logic [W-1:0] bb;
          bb    = sub_in ? ~b_in : b_in;
          full  = {1'b0, a_in} + {1'b0, bb} + (W+1)'(sub_in);
          p_res <= full[W-1:0];
          p_c   <= full[W];
          // Signed overflow: operands (after negation for subtract) share a
          // sign and the result sign differs from it.
          p_v   <= (a_in[W-1] == bb[W-1]) && (full[W-1] != a_in[W-1]);
          m_left <= W + 1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_done <= 1'b1;
          m_res  <= p_res;
          m_c    <= p_c;
          m_v    <= p_v;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (model_on) begin
      chk("model_busy", busy_out, m_left != 0);
      chk("model_done", done_out, m_done);
      chk("model_result", result_out, m_res);
      chk("model_carry", carry_out, m_c);
      chk("model_ovf", overflow_out, m_v);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = -1;
    a_in = a; b_in = b; sub_in = s; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (busy_out) busy_n++;
      if (done_out && done_at < 0) begin
        done_at = i;
        chk({name, "_result"}, result_out, er);
        chk({name, "_carry"}, carry_out, ec);
        chk({name, "_ovf"}, overflow_out, ev);
      end
      // Operand changes while busy must not matter.
      a_in = W'($urandom); b_in = W'($urandom); sub_in = 1'($urandom);
      tick();
    end
    chk({name, "_done_at"}, done_at, W);
    chk({name, "_busy_cycles"}, busy_n, W + 1);
  endtask

  int d1, d2;

  initial begin
    rst_in = 1'b1;
    tick();
    tick();
    chk("reset_busy", busy_out, 1'b0);
    chk("reset_done", done_out, 1'b0);
    chk("reset_result", result_out, 0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_ovf", overflow_out, 1'b0);
    model_on = 1'b1;
    rst_in = 1'b0;
    tick();

    run_op("add_plain", 8'h25, 8'h3A, 1'b0, 8'h5F, 1'b0, 1'b0);
    run_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_borrow",8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub_zero",  8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0);

    // Back-to-back with start held high; operands toggled mid-operation.
    d1 = -1; d2 = -1;
    a_in = 8'h11; b_in = 8'h22; sub_in = 1'b0; start_in = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin a_in = 8'h40; b_in = 8'h05; end
      if (i == 12) start_in = 1'b0;
      if (i == 13) begin a_in = 8'hAA; b_in = 8'h55; sub_in = 1'b1; end
      if (done_out && d1 < 0) begin
        d1 = i;
        chk("b2b_first_result", result_out, 8'h33);
      end else if (done_out && d2 < 0) begin
        d2 = i;
        chk("b2b_second_result", result_out, 8'h45);
      end
      if (i == 14) chk("b2b_result_held", result_out, 8'h33);
      tick();
    end
    chk("b2b_first_done_at", d1, 8);
    chk("b2b_period", d2 - d1, 10);

    // Reset after the 4th SHIFT cycle of 0x25+0x3A.
    a_in = 8'h25; b_in = 8'h3A; sub_in = 1'b0; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_busy_before", busy_out, 1'b1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_busy", busy_out, 1'b0);
    chk("midrst_done", done_out, 1'b0);
    chk("midrst_result", result_out, 0);
    chk("midrst_carry", carry_out, 1'b0);
    chk("midrst_ovf", overflow_out, 1'b0);
    d1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_out || busy_out) d1++;
      tick();
    end
    chk("midrst_no_done", d1, 0);
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Reset and start in the same cycle: reset wins.
    a_in = 8'h12; b_in = 8'h34; rst_in = 1'b1; start_in = 1'b1;
    tick();
    rst_in = 1'b0; start_in = 1'b0;
    chk("collide_busy", busy_out, 1'b0);
    tick();
    chk("collide_busy_next", busy_out, 1'b0);
    chk("collide_result", result_out, 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial N-bit adder/subtractor that drives a single `adder_xor` cell (1-bit full adder with XOR-conditioned B input) over WIDTH cycles, LSB first. It sits directly upstream of the `adder_xor` cell. It sequences operand bits into the cell, holds the inter-bit carry in a flip-flop, and assembles the result word. Handshake is start/busy/done, one operation at a time.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous and active-high.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on an accepted start.
- b_in  input  WIDTH  operand B; captured on an accepted start.
- sub_in  input  1  captured on an accepted start; 0 = A+B, 1 = A−B (two's complement).
- busy_out  output  1  high while the state is SHIFT or DONE.
- done_out  output  1  one-cycle pulse; result outputs are valid from this cycle.
- result_out  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- overflow_out  output  1  signed overflow = (carry into MSB) XOR (carry out of MSB).

## Operation
- The block instantiates one `adder_xor` cell:
  - a_in = a_sh[0]
  - b_in = b_sh[0]
  - c_in = carry_q
  - control_in = sub_q
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start_in=1:
    - capture a_sh←a_in, b_sh←b_in, sub_q←sub_in
    - carry_q←sub_in (provides the +1 for subtract)
    - cnt←0
    - go to SHIFT
  - IDLE, start_in=0: stay in IDLE.
  - SHIFT, each cycle:
    - res_sh←{cell result, res_sh[WIDTH-1:1]}
    - a_sh, b_sh shift right by 1
    - carry_q←cell carry
    - cnt←cnt+1
  - SHIFT, when cnt==WIDTH-1 (last bit):
    - cin_msb←carry_q (value before the update)
    - copy the completed word to result_out, the cell carry to carry_out, and cell carry XOR carry_q to overflow_out
    - go to DONE
  - DONE: go to IDLE unconditionally.
- cnt width is clog2(WIDTH); it does not wrap during SHIFT.
- result_out, carry_out and overflow_out update only on entry to DONE. They hold their value through later operations until the next DONE.
- start_in in SHIFT or DONE is ignored; no queueing.
- Changes on a_in, b_in or sub_in while busy_out=1 have no effect.
- Reset at any point, including mid-SHIFT:
  - next state is IDLE
  - all outputs and internal registers are 0
  - no done_out pulse is generated for the aborted operation
- rst_in has priority over start_in in the same cycle.

## Timing
- Reset values: busy_out=0, done_out=0, result_out=0, carry_out=0, overflow_out=0.
- Start sampled at edge k:
  - busy_out=1 after edge k
  - bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH
  - done_out=1 and results valid after edge k+WIDTH
  - busy_out=0 after edge k+WIDTH+1
- Latency: WIDTH cycles from the start edge to done_out.
- Earliest next accepted start is at edge k+WIDTH+2, giving throughput of one operation per WIDTH+2 cycles.
- done_out is exactly one cycle wide and is always coincident with the final cycle busy_out=1... excepting that busy_out also covers DONE: busy_out and done_out are both high in the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- Add, no overflow: A=0x25, B=0x3A, sub=0 → result 0x5F, carry 0, ovf 0. done_out pulses exactly 8 cycles after the start edge; busy_out is high for 9 cycles.
- Add, carry and overflow:
  - 0xFF+0x01 → 0x00, carry 1, ovf 0
  - 0x7F+0x01 → 0x80, carry 0, ovf 1
- Subtract:
  - 0x05−0x07 → 0xFE, carry 0 (borrow), ovf 0
  - 0x80−0x01 → 0x7F, carry 1, ovf 1
  - 0x10−0x10 → 0x00, carry 1, ovf 0
- Handshake:
  - hold start_in=1 continuously and toggle a_in/b_in mid-operation → results match the operands captured at the start; operations complete back-to-back every 10 cycles
  - result_out holds the previous value until the next done_out
- Reset mid-operation: assert rst_in for one cycle after the 4th SHIFT cycle of 0x25+0x3A → next cycle busy_out=0 and all outputs 0; no done_out pulse. A fresh 0x01+0x02 then returns 0x03.
- Reset/start collision: rst_in=1 and start_in=1 in the same cycle → block stays in IDLE with busy_out=0.
